// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder.
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_slave_state_t;

  // Leading edge leaves the idle level, trailing edge returns to it.
  function automatic logic edge_sel(input logic cpol, input logic leading,
                                    input logic rise, input logic fall);
    logic lead_e;
    logic trail_e;
    lead_e  = cpol ? fall : rise;
    trail_e = cpol ? rise : fall;
    return leading ? lead_e : trail_e;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop pin synchronizer followed by a one-flop edge detector.
module spi_sync #(
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic level_o,
  output logic rise_c,
  output logic fall_c
);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  prev_q, prev_d;

  // Shift the pin through the synchronizer chain and remember the last level.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], async_i};
    prev_d = sync_q[SyncStages-1];
  end

  // Synchronizer and edge-detector flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SyncStages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_c  = level_o & ~prev_q;
  assign fall_c  = ~level_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled SCLK/SS_n/MOSI, all four CPOL/CPHA modes.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WordLength = 8,
  parameter int unsigned SyncStages = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [WordLength-1:0] din_i,
  input  logic                  load_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  output logic [WordLength-1:0] dout_o,
  output logic                  spi_done_tick_o,
  output logic                  busy_o,
  input  logic                  sclk_i,
  input  logic                  ss_ni,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o
);

  localparam int unsigned CntW = (WordLength > 2) ? $clog2(WordLength) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WordLength - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(sclk_i),
    .level_o(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_sync_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(ss_ni),
    .level_o(ss_lvl), .rise_c(ss_rise), .fall_c(ss_fall)
  );

  spi_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .async_i(mosi_i),
    .level_o(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, ss_lvl, mosi_rise, mosi_fall};

  spi_slave_state_t      state_q, state_d;
  logic [WordLength-1:0] tx_buf_q, tx_buf_d;
  logic [WordLength-1:0] so_q, so_d;
  logic [WordLength-1:0] si_q, si_d;
  logic [WordLength-1:0] dout_q, dout_d;
  logic [CntW-1:0]       n_q, n_d;
  logic                  first_q, first_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic                  sample_e, shift_e;
  logic [WordLength-1:0] si_shift;

  // Next-state, shift-register and receive-word logic.
  always_comb begin
    state_d  = state_q;
    tx_buf_d = tx_buf_q;
    so_d     = so_q;
    si_d     = si_q;
    dout_d   = dout_q;
    n_d      = n_q;
    first_d  = first_q;
    wrap_d   = wrap_q;
    done_d   = 1'b0;

    sample_e = edge_sel(cpol_i, ~cpha_i, sclk_rise, sclk_fall);
    shift_e  = edge_sel(cpol_i, cpha_i, sclk_rise, sclk_fall);
    si_shift = {si_q[WordLength-2:0], mosi_lvl};

    if (load_i) begin
      tx_buf_d = din_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_ACTIVE;
          so_d    = tx_buf_q;
          n_d     = '0;
          first_d = 1'b1;
          wrap_d  = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d = ST_IDLE;
        end else begin
          if (sample_e) begin
            si_d = si_shift;
            if (n_q == LastBit) begin
              dout_d = si_shift;
              done_d = 1'b1;
              n_d    = '0;
              wrap_d = 1'b1;
            end else begin
              n_d = n_q + CntW'(1);
            end
          end
          if (shift_e) begin
            if (cpha_i && first_q) begin
              first_d = 1'b0;
            end else if (wrap_q) begin
              // The reload itself presents the new MSB on this shift edge,
              // so no further skip is needed for the next word.
              so_d    = tx_buf_q;
              wrap_d  = 1'b0;
              first_d = 1'b0;
            end else begin
              so_d = {so_q[WordLength-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      tx_buf_q <= '0;
      so_q     <= '0;
      si_q     <= '0;
      dout_q   <= '0;
      n_q      <= '0;
      first_q  <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_buf_q <= tx_buf_d;
      so_q     <= so_d;
      si_q     <= si_d;
      dout_q   <= dout_d;
      n_q      <= n_d;
      first_q  <= first_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign dout_o          = dout_q;
  assign spi_done_tick_o = done_q;
  assign busy_o          = (state_q == ST_ACTIVE);
  assign miso_o          = so_q[WordLength-1];
  assign miso_oe_o       = busy_o;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table-driven mode sweep plus corner sequences.
module tb_spi_slave;

  localparam int unsigned W    = 8;
  localparam int unsigned Half = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [W-1:0] din_i;
  logic         load_i;
  logic         cpol_i;
  logic         cpha_i;
  logic [W-1:0] dout_o;
  logic         spi_done_tick_o;
  logic         busy_o;
  logic         sclk_i;
  logic         ss_ni;
  logic         mosi_i;
  logic         miso_o;
  logic         miso_oe_o;

  spi_slave #(.WordLength(W), .SyncStages(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .din_i(din_i), .load_i(load_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .dout_o(dout_o),
    .spi_done_tick_o(spi_done_tick_o), .busy_o(busy_o),
    .sclk_i(sclk_i), .ss_ni(ss_ni), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o)
  );

  always #5 clk_i = ~clk_i;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_ticks  = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] exp_w;
  logic         tick_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done tick pops one expected word; ticks must be one cycle wide.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (tick_prev) check("tick_width", 32'(spi_done_tick_o), 32'd0);
      if (spi_done_tick_o) begin
        n_ticks++;
        if (sb.size() == 0) begin
          check("unexpected_tick", 32'(spi_done_tick_o), 32'd0);
        end else begin
          exp_w = sb.pop_front();
          check("dout_at_tick", 32'(dout_o), 32'(exp_w));
        end
      end
      tick_prev = spi_done_tick_o;
    end else begin
      tick_prev = 1'b0;
    end
  end

  task automatic half_wait();
    repeat (Half) @(negedge clk_i);
  endtask

  task automatic do_load(input logic [W-1:0] w);
    @(negedge clk_i);
    din_i  = w;
    load_i = 1'b1;
    @(negedge clk_i);
    load_i = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol_i = pol;
    cpha_i = pha;
    sclk_i = pol;
    repeat (10) @(negedge clk_i);
  endtask

  // Master side: drive nbits of tx_w MSB-first, capture MISO on the sample edge.
  task automatic xfer_bits(input logic [W-1:0] tx_w, input int nbits, output logic [W-1:0] rx_w);
    rx_w = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha_i) begin
        mosi_i = tx_w[W-1-i];
        half_wait();
        sclk_i = ~cpol_i;
        rx_w   = {rx_w[W-2:0], miso_o};
        half_wait();
        sclk_i = cpol_i;
      end else begin
        half_wait();
        sclk_i = ~cpol_i;
        mosi_i = tx_w[W-1-i];
        half_wait();
        sclk_i = cpol_i;
        rx_w   = {rx_w[W-2:0], miso_o};
      end
    end
    half_wait();
  endtask

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic [W-1:0] tx;
    logic [W-1:0] mosi_w;
    logic [W-1:0] exp_miso;
    logic [W-1:0] exp_dout;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] rx1, rx2;
  int           t0;
  logic         oe_seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[3] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[6] = '{1'b0, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF};

    rst_ni = 1'b0;
    din_i  = '0;
    load_i = 1'b0;
    cpol_i = 1'b0;
    cpha_i = 1'b0;
    sclk_i = 1'b0;
    ss_ni  = 1'b1;
    mosi_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_dout", 32'(dout_o), 32'd0);
    check("rst_tick", 32'(spi_done_tick_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_miso", 32'(miso_o), 32'd0);
    check("rst_oe", 32'(miso_oe_o), 32'd0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);

    // Mode sweep
    for (int v = 0; v < 8; v++) begin
      set_mode(vecs[v].cpol, vecs[v].cpha);
      do_load(vecs[v].tx);
      t0 = n_ticks;
      sb.push_back(vecs[v].exp_dout);
      ss_ni = 1'b0;
      repeat (6) @(negedge clk_i);
      check("busy_active", 32'(busy_o), 32'd1);
      check("oe_active", 32'(miso_oe_o), 32'd1);
      xfer_bits(vecs[v].mosi_w, 8, rx1);
      ss_ni = 1'b1;
      repeat (10) @(negedge clk_i);
      check("vec_miso", 32'(rx1), 32'(vecs[v].exp_miso));
      check("vec_ticks", 32'(n_ticks - t0), 32'd1);
      check("vec_dout", 32'(dout_o), 32'(vecs[v].exp_dout));
      check("vec_sb_drained", 32'(sb.size()), 32'd0);
      check("vec_busy_idle", 32'(busy_o), 32'd0);
    end

    // Back-to-back words under one SS_n, reload during the first word
    set_mode(1'b0, 1'b0);
    do_load(8'h56);
    t0 = n_ticks;
    sb.push_back(8'h12);
    sb.push_back(8'h34);
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    fork
      xfer_bits(8'h12, 8, rx1);
      begin
        repeat (30) @(negedge clk_i);
        do_load(8'h78);
      end
    join
    xfer_bits(8'h34, 8, rx2);
    ss_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("b2b_miso0", 32'(rx1), 32'h56);
    check("b2b_miso1", 32'(rx2), 32'h78);
    check("b2b_ticks", 32'(n_ticks - t0), 32'd2);
    check("b2b_dout", 32'(dout_o), 32'h34);

    // Abort after 5 bits, then a full word
    t0 = n_ticks;
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    xfer_bits(8'hAB, 5, rx1);
    ss_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("abort_ticks", 32'(n_ticks - t0), 32'd0);
    check("abort_dout", 32'(dout_o), 32'h34);
    sb.push_back(8'hF0);
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    xfer_bits(8'hF0, 8, rx1);
    ss_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("post_abort_ticks", 32'(n_ticks - t0), 32'd1);
    check("post_abort_dout", 32'(dout_o), 32'hF0);
    check("post_abort_miso", 32'(rx1), 32'h78);

    // Asynchronous reset mid-word
    do_load(8'hC3);
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    xfer_bits(8'h99, 3, rx1);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_dout", 32'(dout_o), 32'd0);
    check("arst_tick", 32'(spi_done_tick_o), 32'd0);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_miso", 32'(miso_o), 32'd0);
    check("arst_oe", 32'(miso_oe_o), 32'd0);
    sb.delete();
    ss_ni  = 1'b1;
    sclk_i = cpol_i;
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    t0 = n_ticks;
    sb.push_back(8'h96);
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    xfer_bits(8'h96, 8, rx1);
    ss_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("post_rst_miso", 32'(rx1), 32'h00);
    check("post_rst_dout", 32'(dout_o), 32'h96);
    check("post_rst_ticks", 32'(n_ticks - t0), 32'd1);

    // SCLK activity while deselected is ignored
    t0 = n_ticks;
    oe_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sclk_i = ~sclk_i;
      mosi_i = ~mosi_i;
      repeat (Half) @(negedge clk_i);
      oe_seen = oe_seen | miso_oe_o;
    end
    repeat (10) @(negedge clk_i);
    check("idle_ticks", 32'(n_ticks - t0), 32'd0);
    check("idle_oe", 32'(oe_seen), 32'd0);
    check("idle_bitcnt", 32'(dut.n_q), 32'd0);
    sb.push_back(8'h5C);
    do_load(8'hE1);
    ss_ni = 1'b0;
    repeat (6) @(negedge clk_i);
    xfer_bits(8'h5C, 8, rx1);
    ss_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("after_idle_miso", 32'(rx1), 32'hE1);
    check("after_idle_dout", 32'(dout_o), 32'h5C);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
